// File: rtl/gamma_clk_gen.sv
// Gamma clock generator: programmable period/high-time clock in unit-clock cycles,
// with a one-deep configuration slot applied only on period boundaries or while idle.
module gamma_clk_gen #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEF_PERIOD = 16,
  parameter int unsigned DEF_HIGH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             gamma_clk,
  output logic [CNT_W-1:0] unit_cnt,
  output logic [15:0]      gamma_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic             gamma_clk_q, gamma_clk_d;
  logic [15:0]      gamma_cnt_q, gamma_cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer, cfg_ok, at_end, apply;
  logic [CNT_W-1:0] unit_inc;

  assign cfg_ready = ~pend_valid_q;
  assign xfer      = cfg_valid & cfg_ready;
  assign cfg_ok    = (cfg_period >= Two) && (cfg_high != '0) && (cfg_high < cfg_period);
  // Last cycle of the current period; the following edge is the boundary.
  assign at_end    = (state_q != StIdle) && (unit_cnt_q == act_period_q - One);
  // A pending config lands only where a new period starts or nothing is running.
  assign apply     = pend_valid_q && ((state_q == StIdle) || at_end);
  assign unit_inc  = unit_cnt_q + One;

  // Next-state, counters and configuration slot.
  always_comb begin
    state_d       = state_q;
    unit_cnt_d    = unit_cnt_q;
    gamma_clk_d   = gamma_clk_q;
    gamma_cnt_d   = gamma_cnt_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    cfg_err_d     = xfer & ~cfg_ok;

    if (apply) begin
      act_period_d = pend_period_q;
      act_high_d   = pend_high_q;
      pend_valid_d = 1'b0;
    end
    // apply and xfer are mutually exclusive (xfer needs an empty slot).
    if (xfer && cfg_ok) begin
      pend_valid_d  = 1'b1;
      pend_period_d = cfg_period;
      pend_high_d   = cfg_high;
    end

    case (state_q)
      StIdle: begin
        unit_cnt_d  = '0;
        gamma_clk_d = 1'b0;
        if (en) begin
          state_d     = StRun;
          gamma_clk_d = 1'b1;
          gamma_cnt_d = gamma_cnt_q + 16'd1;
        end
      end
      default: begin
        if (at_end) begin
          unit_cnt_d = '0;
          if (en) begin
            state_d     = StRun;
            gamma_clk_d = 1'b1;
            gamma_cnt_d = gamma_cnt_q + 16'd1;
          end else begin
            state_d     = StIdle;
            gamma_clk_d = 1'b0;
          end
        end else begin
          unit_cnt_d  = unit_inc;
          gamma_clk_d = (unit_inc < act_high_q);
          state_d     = en ? StRun : StStop;
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      unit_cnt_q    <= '0;
      gamma_clk_q   <= 1'b0;
      gamma_cnt_q   <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      unit_cnt_q    <= unit_cnt_d;
      gamma_clk_q   <= gamma_clk_d;
      gamma_cnt_q   <= gamma_cnt_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign gamma_clk = gamma_clk_q;
  assign unit_cnt  = unit_cnt_q;
  assign gamma_cnt = gamma_cnt_q;

endmodule

// File: tb/tb_gamma_clk_gen.sv
// Directed self-checking bench for gamma_clk_gen with default parameters.
module tb_gamma_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic [7:0]  cfg_period;
  logic [7:0]  cfg_high;
  logic        cfg_ready;
  logic        cfg_err;
  logic        gamma_clk;
  logic [7:0]  unit_cnt;
  logic [15:0] gamma_cnt;

  int total = 0;
  int bad   = 0;

  gamma_clk_gen #(
    .CNT_W     (8),
    .DEF_PERIOD(16),
    .DEF_HIGH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .gamma_clk (gamma_clk),
    .unit_cnt  (unit_cnt),
    .gamma_cnt (gamma_cnt)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle 1 ns past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt, cfg_ready, cfg_err} !== {1'b0, 8'd0, 16'd0, 1'b1, 1'b0})
      begin bad++; $display("FAIL reset: got %b/%0d/%0d rdy=%b err=%b want 0/0/0 rdy=1 err=0",
        gamma_clk, unit_cnt, gamma_cnt, cfg_ready, cfg_err); end
    tick; // en=0 after release must not start a period
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b0, 8'd0, 16'd0})
      begin bad++; $display("FAIL idle_no_en: got %b/%0d/%0d want 0/0/0",
        gamma_clk, unit_cnt, gamma_cnt); end
  endtask

  task automatic test_default_run;
    logic [7:0]  eu;
    logic        eg;
    logic [15:0] ec;
    do_reset;
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      eu = 8'((c - 1) % 16);
      eg = (eu < 8);
      ec = 16'((c - 1) / 16 + 1);
      total++;
      if ({gamma_clk, unit_cnt, gamma_cnt} !== {eg, eu, ec})
        begin bad++; $display("FAIL default_run c=%0d: got %b/%0d/%0d want %b/%0d/%0d",
          c, gamma_clk, unit_cnt, gamma_cnt, eg, eu, ec); end
    end
  endtask

  task automatic test_stop_mid_period;
    int highs = 0;
    do_reset;
    en = 1'b1;
    repeat (6) begin tick; if (gamma_clk) highs++; end
    total++;
    if (unit_cnt !== 8'd5) begin bad++; $display("FAIL stop_pre: got %0d want 5", unit_cnt); end
    en = 1'b0;
    for (int c = 7; c <= 16; c++) begin
      tick;
      if (gamma_clk) highs++;
      total++;
      if ({gamma_clk, unit_cnt} !== {(c - 1) < 8, 8'(c - 1)})
        begin bad++; $display("FAIL stop_complete c=%0d: got %b/%0d want %b/%0d",
          c, gamma_clk, unit_cnt, (c - 1) < 8, c - 1); end
    end
    total++;
    if (highs != 8) begin bad++; $display("FAIL stop_highs: got %0d want 8", highs); end
    repeat (2) begin
      tick;
      total++;
      if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b0, 8'd0, 16'd1})
        begin bad++; $display("FAIL stop_idle: got %b/%0d/%0d want 0/0/1",
          gamma_clk, unit_cnt, gamma_cnt); end
    end
  endtask

  task automatic test_cfg_during_run;
    logic [3:0] pat;
    do_reset;
    en = 1'b1;
    repeat (4) tick;
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd1;
    tick; // edge 5: transfer
    cfg_valid = 1'b0;
    total++;
    if ({cfg_ready, unit_cnt} !== {1'b0, 8'd4})
      begin bad++; $display("FAIL cfg_accept: got rdy=%b u=%0d want rdy=0 u=4", cfg_ready, unit_cnt); end
    repeat (11) tick; // edge 16
    total++;
    if ({cfg_ready, gamma_clk, unit_cnt} !== {1'b0, 1'b0, 8'd15})
      begin bad++; $display("FAIL cfg_old_period: got rdy=%b %b/%0d want rdy=0 0/15",
        cfg_ready, gamma_clk, unit_cnt); end
    pat = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if ({gamma_clk, unit_cnt, gamma_cnt, cfg_ready} !== {pat[3 - i], 8'(i), 16'd2, 1'b1})
        begin bad++; $display("FAIL cfg_new_period i=%0d: got %b/%0d/%0d rdy=%b want %b/%0d/2 rdy=1",
          i, gamma_clk, unit_cnt, gamma_cnt, cfg_ready, pat[3 - i], i); end
    end
    tick;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b1, 8'd0, 16'd3})
      begin bad++; $display("FAIL cfg_wrap4: got %b/%0d/%0d want 1/0/3",
        gamma_clk, unit_cnt, gamma_cnt); end
  endtask

  task automatic test_invalid_cfg;
    do_reset;
    en = 1'b1;
    tick;
    cfg_valid = 1'b1; cfg_period = 8'd5; cfg_high = 8'd5;
    tick;
    cfg_valid = 1'b0;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b11)
      begin bad++; $display("FAIL inv1_err: got err=%b rdy=%b want 1 1", cfg_err, cfg_ready); end
    tick;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b01)
      begin bad++; $display("FAIL inv1_pulse: got err=%b rdy=%b want 0 1", cfg_err, cfg_ready); end
    cfg_valid = 1'b1; cfg_period = 8'd1; cfg_high = 8'd0;
    tick;
    cfg_valid = 1'b0;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b11)
      begin bad++; $display("FAIL inv2_err: got err=%b rdy=%b want 1 1", cfg_err, cfg_ready); end
    tick;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b01)
      begin bad++; $display("FAIL inv2_pulse: got err=%b rdy=%b want 0 1", cfg_err, cfg_ready); end
    repeat (11) tick; // edge 16
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b0, 8'd15, 16'd1})
      begin bad++; $display("FAIL inv_timing: got %b/%0d/%0d want 0/15/1",
        gamma_clk, unit_cnt, gamma_cnt); end
    tick;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b1, 8'd0, 16'd2})
      begin bad++; $display("FAIL inv_boundary: got %b/%0d/%0d want 1/0/2",
        gamma_clk, unit_cnt, gamma_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    do_reset;
    en = 1'b1;
    repeat (16) tick;
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd2;
    tick; // edge 17: transfer on boundary edge
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt, cfg_ready} !== {1'b1, 8'd0, 16'd2, 1'b0})
      begin bad++; $display("FAIL b2b_boundary: got %b/%0d/%0d rdy=%b want 1/0/2 rdy=0",
        gamma_clk, unit_cnt, gamma_cnt, cfg_ready); end
    cfg_period = 8'd6; cfg_high = 8'd3; // second offer, slot full
    repeat (3) tick;
    total++;
    if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got %b want 0", cfg_ready); end
    cfg_valid = 1'b0;
    repeat (12) tick; // edge 32
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b0, 8'd15, 16'd2})
      begin bad++; $display("FAIL b2b_full_period: got %b/%0d/%0d want 0/15/2",
        gamma_clk, unit_cnt, gamma_cnt); end
    pat = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if ({gamma_clk, unit_cnt, gamma_cnt, cfg_ready} !== {pat[3 - i], 8'(i), 16'd3, 1'b1})
        begin bad++; $display("FAIL b2b_new i=%0d: got %b/%0d/%0d rdy=%b want %b/%0d/3 rdy=1",
          i, gamma_clk, unit_cnt, gamma_cnt, cfg_ready, pat[3 - i], i); end
    end
    tick;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b1, 8'd0, 16'd4})
      begin bad++; $display("FAIL b2b_wrap4: got %b/%0d/%0d want 1/0/4",
        gamma_clk, unit_cnt, gamma_cnt); end
  endtask

  task automatic test_async_reset;
    do_reset;
    en = 1'b1;
    repeat (4) tick;
    cfg_valid = 1'b1; cfg_period = 8'd4; cfg_high = 8'd1;
    tick;
    cfg_valid = 1'b0;
    repeat (6) tick; // edge 11, unit 10, config pending
    total++;
    if ({unit_cnt, cfg_ready} !== {8'd10, 1'b0})
      begin bad++; $display("FAIL ar_pre: got u=%0d rdy=%b want 10 0", unit_cnt, cfg_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt, cfg_ready, cfg_err} !== {1'b0, 8'd0, 16'd0, 1'b1, 1'b0})
      begin bad++; $display("FAIL ar_clear: got %b/%0d/%0d rdy=%b err=%b want 0/0/0 rdy=1 err=0",
        gamma_clk, unit_cnt, gamma_cnt, cfg_ready, cfg_err); end
    #1 rst_n = 1'b1;
    tick;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b1, 8'd0, 16'd1})
      begin bad++; $display("FAIL ar_start: got %b/%0d/%0d want 1/0/1",
        gamma_clk, unit_cnt, gamma_cnt); end
    repeat (15) tick;
    total++;
    if ({gamma_clk, unit_cnt, gamma_cnt} !== {1'b0, 8'd15, 16'd1})
      begin bad++; $display("FAIL ar_def_period: got %b/%0d/%0d want 0/15/1",
        gamma_clk, unit_cnt, gamma_cnt); end
  endtask

  initial begin
    test_reset;
    test_default_run;
    test_stop_mid_period;
    test_cfg_during_run;
    test_invalid_cfg;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
